// File: rtl/vec_mem_pkg.sv
// vec_mem_pkg: shared states, lane count, default sizes and beat lane-mask helper
package vec_mem_pkg;
  localparam int LANES = 7;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_RAMSIZE = 512;
  localparam int DEF_MAXELEM = 448;
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;
  function automatic logic [LANES-1:0] lane_mask(input int unsigned beat, input int unsigned count);
    logic [LANES-1:0] m;
    for (int k = 0; k < LANES; k++) m[k] = beat * LANES + k < count;
    return m;
  endfunction
endpackage

// File: rtl/vec_mem_sequencer_if.sv
// vec_mem_sequencer_if: request, write/read streams and lane memory port of the sequencer
interface vec_mem_sequencer_if
  import vec_mem_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int RAMSIZE = DEF_RAMSIZE,
  parameter int MAXELEM = DEF_MAXELEM
);
  localparam int AW = $clog2(RAMSIZE);
  localparam int CW = $clog2(MAXELEM + 1);
  logic req_valid, req_ready, req_write;
  logic [AW-1:0] req_base, req_stride;
  logic [CW-1:0] req_count;
  logic wr_valid, wr_ready;
  logic [WIDTH*LANES-1:0] wr_data;
  logic rd_valid, rd_ready;
  logic [WIDTH*LANES-1:0] rd_data;
  logic [LANES-1:0] rd_mask;
  logic done, busy;
  logic [LANES-1:0] mem_we;
  logic [WIDTH*LANES-1:0] mem_a, mem_wd, mem_rd;
  modport master (
    input req_valid, req_write, req_base, req_stride, req_count, wr_valid, wr_data, rd_ready, mem_rd,
    output req_ready, wr_ready, rd_valid, rd_data, rd_mask, done, busy, mem_we, mem_a, mem_wd
  );
  modport slave (
    output req_valid, req_write, req_base, req_stride, req_count, wr_valid, wr_data, rd_ready, mem_rd,
    input req_ready, wr_ready, rd_valid, rd_data, rd_mask, done, busy, mem_we, mem_a, mem_wd
  );
endinterface

// File: rtl/vec_lane_addr_gen.sv
// vec_lane_addr_gen: per-lane address registers, loaded with base+k*stride and stepped by LANES*stride
module vec_lane_addr_gen
  import vec_mem_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic                   adv,
  input  logic [AW-1:0]          base,
  input  logic [AW-1:0]          stride,
  output logic [WIDTH*LANES-1:0] mem_a
);
  logic [LANES:0][AW-1:0] off;
  logic [LANES-1:0][AW-1:0] addr;
  // running sum gives k*stride per lane and LANES*stride as the beat step, all wrapping at AW bits
  always_comb begin
    off[0] = '0;
    for (int k = 1; k <= LANES; k++) off[k] = off[k-1] + stride;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) addr <= '0;
    else if (load) for (int k = 0; k < LANES; k++) addr[k] <= base + off[k];
    else if (adv) for (int k = 0; k < LANES; k++) addr[k] <= addr[k] + off[LANES];
  always_comb
    for (int k = 0; k < LANES; k++) mem_a[k*WIDTH +: WIDTH] = WIDTH'(addr[k]);
endmodule

// File: rtl/vec_mem_sequencer.sv
// vec_mem_sequencer: turns one strided burst request into lane-parallel memory beats
module vec_mem_sequencer
  import vec_mem_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int RAMSIZE = DEF_RAMSIZE,
  parameter int MAXELEM = DEF_MAXELEM
) (
  input logic clk,
  input logic rst_n,
  vec_mem_sequencer_if.master bus
);
  localparam int AW = $clog2(RAMSIZE);
  localparam int CW = $clog2(MAXELEM + 1);
  state_e state, state_n;
  logic [CW-1:0] beat, cnt;
  logic [LANES-1:0] mask, rd_mask;
  logic [WIDTH*LANES-1:0] rd_data, lane_bits;
  logic rd_valid, done, done_n, load, adv, cap, last;
  assign mask = lane_mask(32'(beat), 32'(cnt));
  assign last = lane_mask(32'(beat) + 32'd1, 32'(cnt)) == '0;
  // a read beat is only captured when the output register can take it
  assign cap = state == READ && (!rd_valid || bus.rd_ready);
  always_comb
    for (int k = 0; k < LANES; k++) lane_bits[k*WIDTH +: WIDTH] = {WIDTH{mask[k]}};
  always_comb begin
    state_n = state;
    done_n = 1'b0;
    load = 1'b0;
    adv = 1'b0;
    unique case (state)
      IDLE: if (bus.req_valid) begin
        done_n = bus.req_count == '0;
        load = !done_n;
        state_n = done_n ? IDLE : (bus.req_write ? WRITE : READ);
      end
      READ: adv = cap;
      WRITE: adv = bus.wr_valid;
      default: state_n = IDLE;
    endcase
    if (adv && last) begin
      state_n = IDLE;
      done_n = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      beat <= '0;
      cnt <= '0;
      rd_valid <= 1'b0;
      rd_data <= '0;
      rd_mask <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      done <= done_n;
      if (load) begin
        beat <= '0;
        cnt <= bus.req_count;
      end else if (adv) beat <= beat + CW'(1);
      rd_valid <= cap | (rd_valid & !bus.rd_ready);
      if (cap) begin
        rd_data <= bus.mem_rd & lane_bits;
        rd_mask <= mask;
      end
    end
  vec_lane_addr_gen #(.WIDTH(WIDTH), .AW(AW)) u_addr (
    .clk(clk), .rst_n(rst_n), .load(load), .adv(adv),
    .base(bus.req_base), .stride(bus.req_stride), .mem_a(bus.mem_a)
  );
  assign bus.req_ready = state == IDLE;
  assign bus.busy = state != IDLE;
  assign bus.wr_ready = state == WRITE;
  assign bus.mem_we = state == WRITE ? mask & {LANES{bus.wr_valid}} : '0;
  assign bus.mem_wd = bus.wr_data;
  assign bus.rd_valid = rd_valid;
  assign bus.rd_data = rd_data;
  assign bus.rd_mask = rd_mask;
  assign bus.done = done;
endmodule

// File: doc/vec_mem_sequencer.md
Name: vec_mem_sequencer

Overview:
Initiator for the 7-lane unified data memory: turns one strided burst request into a sequence of lane-parallel memory beats. Drives the memory's per-lane write enables, addresses and write data, and samples its combinational per-lane read data. Sits between the pipeline's vector load/store stage and the memory. Streams write data in, and read data out, with valid/ready handshakes.

Parameters:
WIDTH, 32, data word width and per-lane address field width on the memory port
RAMSIZE, 512, words per lane; lane addresses are reduced modulo RAMSIZE (power of two)
LANES, 7, number of memory lanes / elements per beat
MAXELEM, 448, maximum elements per request
(derived, not overridable: AW = $clog2(RAMSIZE), CW = $clog2(MAXELEM+1))

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  1  request offered
req_ready  out  1  request accepted when high with req_valid
req_write  in  1  1 = store burst, 0 = load burst
req_base  in  AW  element-0 address
req_stride  in  AW  address step between consecutive elements
req_count  in  CW  element count, 0..MAXELEM
wr_valid  in  1  write beat offered
wr_ready  out  1  write beat consumed when high with wr_valid
wr_data  in  WIDTH*LANES  lane k data in bits [WIDTH*(k+1)-1:WIDTH*k]
rd_valid  out  1  read beat held in the output register
rd_ready  in  1  consumer takes the read beat
rd_data  out  WIDTH*LANES  read beat; disabled lanes are zero
rd_mask  out  LANES  enabled lanes of the current read beat
done  out  1  one-cycle pulse, burst finished
busy  out  1  high in READ/WRITE
mem_we  out  LANES  per-lane write enables to memory
mem_a  out  WIDTH*LANES  per-lane addresses, zero-extended from AW
mem_wd  out  WIDTH*LANES  per-lane write data
mem_rd  in  WIDTH*LANES  per-lane combinational read data

Behaviour:
- Element i of a burst goes to lane i mod LANES on beat i/LANES, at address (base + i*stride) mod RAMSIZE.
- Beats = ceil(count/LANES).
- Lane mask for a beat: lane k is enabled iff beat*LANES+k < count.
- Per-lane address registers load base+k*stride on acceptance. Each beat advance adds LANES*stride, with AW-bit wrap; no multipliers in the datapath.
- States: IDLE, READ, WRITE.
- IDLE: req_ready=1, busy=0, mem_we=0.
  - On req_valid with count=0: no memory access; done=1 next cycle; stay IDLE.
  - Otherwise: latch the request, beat=0, go to READ or WRITE.
- READ: req_ready=0.
  - A beat is captured when the output register is free (!rd_valid or rd_ready).
  - On capture: rd_data <= mem_rd with disabled lanes zeroed; rd_mask <= lane mask; rd_valid <= 1; advance the beat.
  - After the last beat is captured: go to IDLE, done pulse in the same edge.
  - First rd_valid appears 2 cycles after the request handshake.
  - With rd_ready held high: one beat per cycle.
- rd_valid clears on rd_ready when nothing new is captured. The output register persists across IDLE and the next request.
  - A new READ stalls until the register is free.
  - rd_data, rd_mask and mem_a are stable while stalled.
- WRITE: wr_ready=1; mem_wd=wr_data.
  - mem_we = lane mask & {LANES{wr_valid}}; memory writes on that edge.
  - Beat advances on each wr handshake. Last handshake: go to IDLE, done pulse.
- mem_a always reflects the current beat's lane registers. Valid in IDLE too (last values, or 0 after reset).
- Reset (asynchronous, any state): state=IDLE, rd_valid=0, rd_data=0, rd_mask=0, done=0, lane address registers=0. mem_we=0 immediately, without waiting for a clock. An in-flight burst is abandoned; no further writes.
- req_count > MAXELEM is illegal; behaviour is not checked.

Decomposition:
- Package vec_mem_pkg: state enum (IDLE/READ/WRITE), LANES, default WIDTH/RAMSIZE, and a lane-mask function (beat, count -> LANES bits).
- One sub-module: vec_lane_addr_gen. It holds the LANES address registers, the load/advance logic and the mem_a packing.

Test Plan:
- Load base=0, stride=1, count=10 (memory preloaded mem[k]=k+100) -> 2 beats.
  - Beat0: lanes 0..6 = 100..106, mask 1111111.
  - Beat1: lanes 0..2 = 107..109, lanes 3..6 = 0, mask 0000111.
  - done one cycle after beat1 is captured.
- Store base=20, stride=2, count=7, wr_data lane k = 0xA0+k -> single cycle with mem_we=1111111. Memory addresses 20,22,..,32 hold 0xA0..0xA6; odd addresses untouched.
- Wrap: load base=510, stride=1, count=3 -> mem_a lanes = 510, 511, 0; mask 0000111.
- Backpressure: load count=14 with rd_ready low for 3 cycles after the first rd_valid -> rd_data/mem_a frozen, no beat lost. Exactly 2 beats are delivered, then done.
- count=0 request -> req_ready handshake, done pulse next cycle, mem_we never asserted, busy stays 0.
- rst_n low mid-store (after beat 1 of 3, wr_valid high) -> mem_we=0 asynchronously, no further memory writes. After release: IDLE, req_ready=1, rd_valid=0.
